// File: rtl/axi4_lite_reg_bank_if.sv
// AXI4-Lite bus bundle for the register bank: the master modport drives
// requests, and the slave modport answers them.
interface axi4_lite_reg_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave with NUM_RW byte-writable registers and NUM_RO sampled status words.
// AW and W are captured independently; read and write paths run concurrently.
module axi4_lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_RW     = 8,
  parameter int NUM_RO     = 4,
  parameter logic [NUM_RW*DATA_WIDTH-1:0] RW_RESET = '0
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  axi4_lite_reg_bank_if.slave         s_axi,
  output logic [NUM_RW*DATA_WIDTH-1:0] rw_regs,
  input  logic [((NUM_RO == 0) ? 1 : NUM_RO*DATA_WIDTH)-1:0] ro_regs,
  output logic [NUM_RW-1:0]           wr_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int RW_W   = NUM_RW * DATA_WIDTH;

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_RW-1:0]     wr_pulse_q, wr_pulse_d;
  logic [RW_W-1:0]       rw_q, rw_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_is_rw_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s, rd_data_s;
  logic [STRB_W-1:0]     wr_strb_s;
  logic [63:0]           wr_idx_s, rd_idx_s;
  logic [1:0]            rd_resp_s;

  // Write path: channel capture, commit on the edge where both halves are available.
  always_comb begin
    aw_hs_s    = s_axi.AWVALID & awready_q;
    w_hs_s     = s_axi.WVALID & wready_q;
    wr_addr_s  = aw_held_q ? aw_addr_q : s_axi.AWADDR;
    wr_data_s  = w_held_q ? w_data_q : s_axi.WDATA;
    wr_strb_s  = w_held_q ? w_strb_q : s_axi.WSTRB;
    commit_s   = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s);
    wr_idx_s   = 64'(wr_addr_s >> 2);
    wr_is_rw_s = (wr_idx_s < 64'(NUM_RW));

    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    rw_d       = rw_q;

    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        aw_addr_d = s_axi.AWADDR;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        w_data_d = s_axi.WDATA;
        w_strb_d = s_axi.WSTRB;
      end else begin
        w_held_d = w_held_q;
      end
    end

    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_is_rw_s ? 2'b00 : 2'b10;
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_is_rw_s && (wr_idx_s == 64'(i))) begin
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb_s[b]) begin
              rw_d[i*DATA_WIDTH + b*8 +: 8] = wr_data_s[b*8 +: 8];
            end else begin
              rw_d[i*DATA_WIDTH + b*8 +: 8] = rw_q[i*DATA_WIDTH + b*8 +: 8];
            end
          end
        end else begin
          wr_pulse_d[i] = 1'b0;
        end
      end
    end else if (bvalid_q && s_axi.BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    // Readies stay low while a payload is held or a response is pending.
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // Read path: decode and sample the source on the AR handshake.
  always_comb begin
    ar_hs_s   = s_axi.ARVALID & arready_q;
    rd_idx_s  = 64'(s_axi.ARADDR >> 2);
    rd_data_s = '0;
    rd_resp_s = 2'b10;
    for (int i = 0; i < NUM_RW; i++) begin
      if (rd_idx_s == 64'(i)) begin
        rd_data_s = rw_q[i*DATA_WIDTH +: DATA_WIDTH];
        rd_resp_s = 2'b00;
      end else begin
        rd_data_s = rd_data_s;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (rd_idx_s == 64'(NUM_RW + j)) begin
        rd_data_s = ro_regs[j*DATA_WIDTH +: DATA_WIDTH];
        rd_resp_s = 2'b00;
      end else begin
        rd_data_s = rd_data_s;
      end
    end

    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_s;
      rresp_d  = rd_resp_s;
    end else if (rvalid_q && s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = ~rvalid_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      rw_q       <= RW_RESET;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rw_q       <= rw_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign rw_regs       = rw_q;
  assign wr_pulse      = wr_pulse_q;
endmodule

// File: doc/axi4_lite_reg_bank.md
AXI4_LITE_REG_BANK -- requirements
Module: axi4_lite_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI data width, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 SHALL have parameter NUM_RW, default 8, range 1..64: number of read/write registers.
REQ-004 SHALL have parameter NUM_RO, default 4, range 0..64: number of read-only status registers.
REQ-005 SHALL have parameter RW_RESET, default all zero, NUM_RW*DATA_WIDTH bits: per-register reset values, register i in slice i.
REQ-006 SHALL have port ACLK, input, 1 bit: clock, all logic on the rising edge.
REQ-007 SHALL have port ARESETN, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have the AXI4-Lite slave ports AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP(2)/BVALID/BREADY, ARADDR/ARVALID/ARREADY and RDATA/RRESP(2)/RVALID/RREADY, with standard directions and widths.
REQ-009 SHALL have port rw_regs, output, NUM_RW*DATA_WIDTH bits: current read/write register contents, register i in slice i.
REQ-010 SHALL have port ro_regs, input, NUM_RO*DATA_WIDTH bits (minimum 1 bit when NUM_RO=0): status values that are sampled on read.
REQ-011 SHALL have port wr_pulse, output, NUM_RW bits: bit i is a one-cycle strobe following a committed write to register i.

Function
REQ-012 SHALL use word index = ADDR[ADDR_WIDTH-1:2] and ignore ADDR[1:0].
REQ-013 SHALL decode the word index as follows:
- index below NUM_RW: read/write register.
- index from NUM_RW up to NUM_RW+NUM_RO-1: read-only register (index - NUM_RW).
- any other index: unmapped.
REQ-014 SHALL handle the AW and W channels independently.
- AWREADY is high while no address is held; WREADY is high while no data is held.
- Each channel captures its payload on its own handshake, and the two may complete in either order or on the same edge.
REQ-015 SHALL commit a write on the edge where both address and data are held or being captured.
- For a read/write target, only the byte lanes with WSTRB[b]=1 are updated.
- WSTRB=0 is a legal write that leaves the register unchanged, but still produces OKAY and a wr_pulse.
REQ-016 SHALL, for a write to a read-only or unmapped index, leave all registers unchanged, produce no wr_pulse and respond with BRESP=2'b10 (SLVERR); a write to a read/write register responds with 2'b00.
REQ-017 SHALL assert BVALID on the cycle after commit and hold BVALID and BRESP stable until BREADY.
- AWREADY and WREADY stay low from commit until the B handshake completes.
- Both return high on the cycle after the B handshake.
REQ-018 SHALL assert wr_pulse[i] for exactly the one cycle after the commit edge.
REQ-019 SHALL keep ARREADY high while no read response is pending.
- On the AR handshake, RDATA and RRESP are registered from the decoded source; the value sampled is the pre-edge register contents or the current ro_regs.
- RVALID is high from the next cycle.
REQ-020 SHALL return RDATA=0 with RRESP=2'b10 for an unmapped read.
REQ-021 SHALL hold RVALID, RDATA and RRESP stable until RREADY and keep ARREADY low meanwhile; ARREADY returns high on the cycle after the R handshake.
REQ-022 SHALL run the read and write paths concurrently.
- A read sampled on the same edge as a write commit to the same register returns the old value.
- That read returns the new value on the next access.
REQ-023 SHALL not accept a new transaction on either path until the previous response handshake completes, so at most one read and one write are outstanding.

Reset
REQ-024 SHALL, while ARESETN=0 at a rising edge, apply the following on that edge:
- rw_regs take RW_RESET.
- AWREADY, WREADY, ARREADY, BVALID, RVALID and wr_pulse go to 0.
- BRESP, RRESP and RDATA go to 0.
- All held address and data payloads are discarded.
REQ-025 SHALL raise AWREADY, WREADY and ARREADY on the first edge with ARESETN=1.
REQ-026 SHALL abandon any transaction in flight when reset is asserted, issuing no response and no wr_pulse for it.

Verification
REQ-027 SHALL verify a split-order write: W (WDATA=0xDEADBEEF, WSTRB=0xF) two cycles before AW (AWADDR=0x08) -> reg2=0xDEADBEEF, BRESP=00, wr_pulse[2] high for exactly one cycle.
REQ-028 SHALL verify byte strobes: reg1=0x11223344, then write 0xAABBCCDD with WSTRB=0x5 -> reg1=0x11BB33DD.
REQ-029 SHALL verify the read-only and unmapped paths with ro_regs word0=0xCAFE0001:
- Read 0x20 -> RDATA 0xCAFE0001, RRESP 00.
- Write 0x20 -> SLVERR and no change.
- Read 0x40 -> RDATA 0, RRESP 10.
REQ-030 SHALL verify backpressure: BREADY and RREADY held low for 5 cycles -> BVALID, RVALID, BRESP, RDATA and RRESP are stable, and AWREADY, WREADY and ARREADY stay low until the handshake.
REQ-031 SHALL verify a same-edge read and write to reg0 (old 0x1, new 0x2) -> the read returns 0x1 and the following read returns 0x2.
REQ-032 SHALL verify reset mid-write: ARESETN pulsed low after the AW handshake only -> no BVALID, no wr_pulse, reg at RW_RESET, and readies high one cycle after release.
